// File: rtl/fp16_pkg.sv
// Shared binary16 field widths, packed operand view and classification helpers for the fp16 add pipeline.
package fp16_pkg;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;
    localparam int GRS_W = 3;
    localparam int BIAS  = 15;
    localparam int MAG_W = 1 + MAN_W + GRS_W;

    localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp16_t;

    function automatic logic is_nan(input fp16_t v);
        return (v.exp == EXP_MAX) && (v.frac != '0);
    endfunction

    function automatic logic is_inf(input fp16_t v);
        return (v.exp == EXP_MAX) && (v.frac == '0);
    endfunction

    // Subnormals and zero share the exponent of the smallest normal.
    function automatic logic [EXP_W-1:0] eff_exp(input fp16_t v);
        return (v.exp == '0) ? EXP_W'(1) : v.exp;
    endfunction

    function automatic logic [MAG_W-1:0] significand(input fp16_t v);
        return {(v.exp != '0), v.frac, {GRS_W{1'b0}}};
    endfunction

endpackage

// File: rtl/fp16_sticky_shifter.sv
// Combinational right shift of an aligned significand; saturates to zero past the full width.
// FP16_ALIGN_STICKY_EN folds every shifted-out bit into bit 0; otherwise plain truncation.
module fp16_sticky_shifter
    import fp16_pkg::*;
(
    input  logic [MAG_W-1:0] i_mag,
    input  logic [EXP_W-1:0] i_shamt,
    output logic [MAG_W-1:0] o_mag
);

    localparam logic [EXP_W-1:0] SAT = EXP_W'(MAG_W);

    logic [MAG_W-1:0] shifted;

`ifdef FP16_ALIGN_STICKY_EN
    logic sticky;

    always_comb begin
        shifted = (i_shamt >= SAT) ? '0 : (i_mag >> i_shamt);
        sticky  = 1'b0;
        for (int i = 0; i < MAG_W; i++) begin
            if (EXP_W'(i) < i_shamt) begin
                sticky = sticky | i_mag[i];
            end
        end
        o_mag = {shifted[MAG_W-1:1], shifted[0] | sticky};
    end
`else
    always_comb begin
        shifted = (i_shamt >= SAT) ? '0 : (i_mag >> i_shamt);
        o_mag   = shifted;
    end
`endif

endmodule

// File: rtl/fp16_align_stage.sv
// Two-stage fp16 operand unpack/align ahead of the magnitude adder; 2-cycle latency, 1 op/cycle.
// Valid/ready stall chain: o_ready is combinational from i_ready; FP16_ALIGN_STICKY_EN enables sticky OR.
module fp16_align_stage
    import fp16_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [EXP_W+MAN_W:0]   i_lhs,
    input  logic [EXP_W+MAN_W:0]   i_rhs,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [EXP_W-1:0]       o_exp,
    output logic                   o_lhs_sign,
    output logic [MAG_W-1:0]       o_lhs_magnitude,
    output logic                   o_rhs_sign,
    output logic [MAG_W-1:0]       o_rhs_magnitude,
    output logic                   o_nan,
    output logic                   o_inf
);

    fp16_t lhs, rhs;
    assign lhs = fp16_t'(i_lhs);
    assign rhs = fp16_t'(i_rhs);

    logic rdy_q;
    logic s1_valid_q, s2_valid_q;
    logic s1_en, s2_en, accept;

    assign s2_en   = !s2_valid_q || i_ready;
    assign s1_en   = !s1_valid_q || s2_en;
    assign o_ready = s1_en && rdy_q;
    assign accept  = i_valid && o_ready;

    // Stage 1 next state
    logic [EXP_W-1:0] s1_lhs_exp_d, s1_rhs_exp_d, s1_diff_d;
    logic             s1_lhs_big_d, s1_nan_d, s1_inf_d, s1_lhs_sign_d;

    always_comb begin
        s1_lhs_exp_d = eff_exp(lhs);
        s1_rhs_exp_d = eff_exp(rhs);
        s1_lhs_big_d = s1_lhs_exp_d >= s1_rhs_exp_d;
        s1_diff_d    = s1_lhs_big_d ? (s1_lhs_exp_d - s1_rhs_exp_d) : (s1_rhs_exp_d - s1_lhs_exp_d);
        s1_nan_d     = is_nan(lhs) || is_nan(rhs) ||
                       (is_inf(lhs) && is_inf(rhs) && (lhs.sign != rhs.sign));
        s1_inf_d     = !s1_nan_d && (is_inf(lhs) || is_inf(rhs));
        // An infinite result reports its sign on the lhs lane even when only rhs is infinite.
        s1_lhs_sign_d = (s1_inf_d && !is_inf(lhs)) ? rhs.sign : lhs.sign;
    end

    logic [MAG_W-1:0] s1_lhs_sig_q, s1_rhs_sig_q;
    logic [EXP_W-1:0] s1_lhs_exp_q, s1_rhs_exp_q, s1_diff_q;
    logic             s1_lhs_big_q, s1_nan_q, s1_inf_q, s1_lhs_sign_q, s1_rhs_sign_q;

    // Stage 2 next state
    logic [MAG_W-1:0] shift_in, shift_out;
    logic [MAG_W-1:0] s2_lhs_mag_d, s2_rhs_mag_d;
    logic [EXP_W-1:0] s2_exp_d;

    assign shift_in     = s1_lhs_big_q ? s1_rhs_sig_q : s1_lhs_sig_q;
    assign s2_lhs_mag_d = s1_lhs_big_q ? s1_lhs_sig_q : shift_out;
    assign s2_rhs_mag_d = s1_lhs_big_q ? shift_out : s1_rhs_sig_q;
    assign s2_exp_d     = s1_lhs_big_q ? s1_lhs_exp_q : s1_rhs_exp_q;

    fp16_sticky_shifter u_shifter (
        .i_mag   (shift_in),
        .i_shamt (s1_diff_q),
        .o_mag   (shift_out)
    );

    logic [EXP_W-1:0] exp_q;
    logic [MAG_W-1:0] lhs_mag_q, rhs_mag_q;
    logic             lhs_sign_q, rhs_sign_q, nan_q, inf_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rdy_q         <= 1'b0;
            s1_valid_q    <= 1'b0;
            s1_lhs_sig_q  <= '0;
            s1_rhs_sig_q  <= '0;
            s1_lhs_exp_q  <= '0;
            s1_rhs_exp_q  <= '0;
            s1_diff_q     <= '0;
            s1_lhs_big_q  <= 1'b0;
            s1_nan_q      <= 1'b0;
            s1_inf_q      <= 1'b0;
            s1_lhs_sign_q <= 1'b0;
            s1_rhs_sign_q <= 1'b0;
            s2_valid_q    <= 1'b0;
            exp_q         <= '0;
            lhs_mag_q     <= '0;
            rhs_mag_q     <= '0;
            lhs_sign_q    <= 1'b0;
            rhs_sign_q    <= 1'b0;
            nan_q         <= 1'b0;
            inf_q         <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (s1_en) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_lhs_sig_q  <= significand(lhs);
                    s1_rhs_sig_q  <= significand(rhs);
                    s1_lhs_exp_q  <= s1_lhs_exp_d;
                    s1_rhs_exp_q  <= s1_rhs_exp_d;
                    s1_diff_q     <= s1_diff_d;
                    s1_lhs_big_q  <= s1_lhs_big_d;
                    s1_nan_q      <= s1_nan_d;
                    s1_inf_q      <= s1_inf_d;
                    s1_lhs_sign_q <= s1_lhs_sign_d;
                    s1_rhs_sign_q <= rhs.sign;
                end
            end
            if (s2_en) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    exp_q      <= s2_exp_d;
                    lhs_mag_q  <= s2_lhs_mag_d;
                    rhs_mag_q  <= s2_rhs_mag_d;
                    lhs_sign_q <= s1_lhs_sign_q;
                    rhs_sign_q <= s1_rhs_sign_q;
                    nan_q      <= s1_nan_q;
                    inf_q      <= s1_inf_q;
                end
            end
        end
    end

    assign o_valid         = s2_valid_q;
    assign o_exp           = exp_q;
    assign o_lhs_sign      = lhs_sign_q;
    assign o_lhs_magnitude = lhs_mag_q;
    assign o_rhs_sign      = rhs_sign_q;
    assign o_rhs_magnitude = rhs_mag_q;
    assign o_nan           = nan_q;
    assign o_inf           = inf_q;

endmodule

// File: tb/tb_fp16_align_stage.sv
// Directed-vector bench for fp16_align_stage: unpack/align values, specials, stall stream and mid-flight reset.
module tb_fp16_align_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [15:0] i_lhs, i_rhs;
    logic        o_valid;
    logic        i_ready;
    logic [4:0]  o_exp;
    logic        o_lhs_sign, o_rhs_sign;
    logic [13:0] o_lhs_magnitude, o_rhs_magnitude;
    logic        o_nan, o_inf;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef FP16_ALIGN_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    always #5 i_clk = ~i_clk;

    fp16_align_stage dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_valid         (i_valid),
        .o_ready         (o_ready),
        .i_lhs           (i_lhs),
        .i_rhs           (i_rhs),
        .o_valid         (o_valid),
        .i_ready         (i_ready),
        .o_exp           (o_exp),
        .o_lhs_sign      (o_lhs_sign),
        .o_lhs_magnitude (o_lhs_magnitude),
        .o_rhs_sign      (o_rhs_sign),
        .o_rhs_magnitude (o_rhs_magnitude),
        .o_nan           (o_nan),
        .o_inf           (o_inf)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation through an idle pipe; results checked two edges after the accept.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [4:0] e_exp, input logic [13:0] e_lm, input logic e_ls,
                          input logic [13:0] e_rm, input logic e_rs,
                          input logic e_nan, input logic e_inf, input bit chk_mag);
        @(negedge i_clk);
        check({tag, "_ready"}, 32'(o_ready), 32'd1);
        i_valid = 1'b1;
        i_lhs   = a;
        i_rhs   = b;
        @(negedge i_clk);
        i_valid = 1'b0;
        check({tag, "_early_valid"}, 32'(o_valid), 32'd0);
        @(negedge i_clk);
        check({tag, "_valid"}, 32'(o_valid), 32'd1);
        check({tag, "_nan"}, 32'(o_nan), 32'(e_nan));
        check({tag, "_inf"}, 32'(o_inf), 32'(e_inf));
        check({tag, "_lsign"}, 32'(o_lhs_sign), 32'(e_ls));
        if (chk_mag) begin
            check({tag, "_exp"}, 32'(o_exp), 32'(e_exp));
            check({tag, "_lmag"}, 32'(o_lhs_magnitude), 32'(e_lm));
            check({tag, "_rmag"}, 32'(o_rhs_magnitude), 32'(e_rm));
            check({tag, "_rsign"}, 32'(o_rhs_sign), 32'(e_rs));
        end
    endtask

    logic [15:0] s_rhs [4];
    logic [13:0] s_mag [4];

    initial begin
        int in_idx, out_idx, stall_left, late_valid;
        bit stalled_once, saw_block;

        s_rhs = '{16'h3C00, 16'h3800, 16'h3400, 16'h3000};
        s_mag = '{14'h2000, 14'h1000, 14'h0800, 14'h0400};

        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        i_lhs   = '0;
        i_rhs   = '0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        check("rst_exp", 32'(o_exp), 32'd0);
        check("rst_lmag", 32'(o_lhs_magnitude), 32'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("rel_ready", 32'(o_ready), 32'd1);

        run_op("one_one",   16'h3C00, 16'h3C00, 5'd15, 14'h2000, 1'b0, 14'h2000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("one_mhalf", 16'h3C00, 16'hB800, 5'd15, 14'h2000, 1'b0, 14'h1000, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("d14",       16'h3C00, 16'h0001, 5'd15, 14'h2000, 1'b0, {13'd0, STICKY}, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("d4_sticky", 16'h3C00, 16'h2C01, 5'd15, 14'h2000, 1'b0, {13'h0100, STICKY}, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("lhs_shift", 16'h3800, 16'h3C03, 5'd15, 14'h1000, 1'b0, 14'h2018, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("zeros",     16'h0000, 16'h0000, 5'd1,  14'h0000, 1'b0, 14'h0000, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op("nan_lhs",   16'h7E00, 16'h3C00, 5'd0,  14'h0,    1'b0, 14'h0,    1'b0, 1'b1, 1'b0, 1'b0);
        run_op("inf_diff",  16'h7C00, 16'hFC00, 5'd0,  14'h0,    1'b0, 14'h0,    1'b0, 1'b1, 1'b0, 1'b0);
        run_op("inf_pos",   16'h7C00, 16'h3C00, 5'd0,  14'h0,    1'b0, 14'h0,    1'b0, 1'b0, 1'b1, 1'b0);
        run_op("inf_rhs",   16'h3C00, 16'hFC00, 5'd0,  14'h0,    1'b1, 14'h0,    1'b0, 1'b0, 1'b1, 1'b0);

        // Back-to-back stream with a 3-cycle downstream stall at the first result.
        in_idx = 0; out_idx = 0; stall_left = 0; stalled_once = 0; saw_block = 0;
        for (int cyc = 0; cyc < 40 && out_idx < 4; cyc++) begin
            @(negedge i_clk);
            if (o_valid && !stalled_once) begin
                stalled_once = 1;
                stall_left   = 3;
            end
            i_ready = (stall_left == 0);
            if (in_idx < 4) begin
                i_valid = 1'b1;
                i_lhs   = 16'h3C00;
                i_rhs   = s_rhs[in_idx];
            end else begin
                i_valid = 1'b0;
            end
            #1;
            if (stall_left > 0) begin
                check("stall_valid", 32'(o_valid), 32'd1);
                check("stall_rmag", 32'(o_rhs_magnitude), 32'(s_mag[0]));
                check("stall_exp", 32'(o_exp), 32'd15);
                if (!o_ready) saw_block = 1;
                stall_left--;
            end
            if (i_valid && o_ready) in_idx++;
            if (o_valid && i_ready) begin
                check("stream_order", 32'(o_rhs_magnitude), 32'(s_mag[out_idx]));
                out_idx++;
            end
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("stream_count", 32'(out_idx), 32'd4);
        check("stream_blocked", 32'(saw_block), 32'd1);
        @(negedge i_clk);
        check("stream_no_dup", 32'(o_valid), 32'd0);

        // Reset with two operations in flight.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_lhs   = 16'h3C00;
        i_rhs   = 16'h3C00;
        @(negedge i_clk);
        i_rhs   = 16'h3800;
        @(negedge i_clk);
        i_valid = 1'b0;
        check("inflight_valid", 32'(o_valid), 32'd1);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("mrst_valid", 32'(o_valid), 32'd0);
        check("mrst_exp", 32'(o_exp), 32'd0);
        check("mrst_lmag", 32'(o_lhs_magnitude), 32'd0);
        check("mrst_rmag", 32'(o_rhs_magnitude), 32'd0);
        check("mrst_ready", 32'(o_ready), 32'd0);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        late_valid = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge i_clk);
            if (o_valid) late_valid++;
        end
        check("mrst_no_stale", 32'(late_valid), 32'd0);
        check("mrst_ready_after", 32'(o_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp16_align_stage.md
Name: fp16_align_stage

Overview:
- Upstream neighbour of the sign-magnitude adder in the fp16 add pipeline.
- Unpacks two IEEE-754 binary16 operands and finds the common (larger) exponent.
- Right-shifts the smaller-exponent significand into guard/round/sticky positions.
- Emits sign/magnitude pairs ready for magnitude addition.
- Two register stages, valid/ready handshake, one operation per cycle.

Parameters:
- EXP_W, 5: exponent width.
- MAN_W, 10: stored fraction width.
- GRS_W, 3: extra low bits below the fraction (guard, round, sticky).

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  synchronous active-low reset
- i_valid  input  1  operand pair valid
- o_ready  output  1  stage can accept operands
- i_lhs  input  1+EXP_W+MAN_W  lhs operand, binary16 encoding
- i_rhs  input  1+EXP_W+MAN_W  rhs operand, binary16 encoding
- o_valid  output  1  aligned result valid
- i_ready  input  1  downstream (adder stage) accepts
- o_exp  output  EXP_W  common exponent, effective (biased) value
- o_lhs_sign  output  1  lhs sign
- o_lhs_magnitude  output  1+MAN_W+GRS_W  aligned lhs significand
- o_rhs_sign  output  1  rhs sign
- o_rhs_magnitude  output  1+MAN_W+GRS_W  aligned rhs significand
- o_nan  output  1  either operand NaN, or +inf + -inf
- o_inf  output  1  result is infinity (o_nan=0); sign on o_lhs_sign

Behaviour:
- Reset is synchronous, active low, on i_clk. It clears both stage valid bits and drives all outputs to 0; o_ready goes 1 in the cycle after reset releases.
- Reset mid-operation discards in-flight data. No o_valid pulse follows.
- Latency is 2 cycles from the i_valid&&o_ready accept edge to o_valid. Throughput is 1 per cycle.
- Stall logic:
  - s2_en = !s2_valid || i_ready
  - s1_en = !s1_valid || s2_en
  - o_ready = s1_en (combinational through the stall chain)
- While o_valid && !i_ready, all outputs hold stable.
- Stage 1 (unpack):
  - Effective exponent = exp==0 ? 1 : exp.
  - Hidden bit = (exp != 0).
  - Significand = {hidden, frac, GRS_W'b0}, 14 bits by default.
  - Register the signs, significands, effective exponents, d = |eA-eB|, and a select of the larger exponent.
  - Classify NaN (exp all ones, frac != 0) and Inf (exp all ones, frac == 0).
- Stage 2 (align):
  - o_exp = max effective exponent.
  - The larger-exponent operand passes unshifted. The other is shifted right by d.
  - If d >= 1+MAN_W+GRS_W, the shifted value is 0 before the sticky OR.
  - On equal exponents neither operand is shifted.
  - Operand order is preserved (lhs stays lhs). No magnitude swap here; the adder swaps.
- Special cases:
  - o_nan = NaN(lhs) || NaN(rhs) || (Inf(lhs) && Inf(rhs) && signs differ).
  - o_inf = !o_nan && (Inf(lhs) || Inf(rhs)).
  - When o_inf, o_lhs_sign carries the infinity's sign.
  - Magnitudes are don't-care when o_nan or o_inf is set, but must be deterministic (aligned values as computed).
- Zero operands align as normal values with effective exponent 1.

Optional Feature:
- Macro: FP16_ALIGN_STICKY_EN.
- Defined: bit 0 of the shifted magnitude is the OR of the original bit 0 and every bit shifted out, including the fully-shifted-out case.
- Undefined: shifted-out bits are discarded (pure truncation) and bit 0 is a plain shift result. Port list is identical in both builds.

Decomposition:
- Shared package fp16_pkg:
  - EXP_W, MAN_W, GRS_W, BIAS=15
  - EXP_MAX=5'h1F
  - MAG_W = 1+MAN_W+GRS_W
  - packed-field typedef {sign, exp, frac}
  - classify helpers is_nan/is_inf
- One natural sub-module: fp16_sticky_shifter. Combinational right shift with saturation and sticky OR, instantiated once in stage 2.

Test Plan:
- 0x3C00 + 0x3C00, i_ready=1 → two cycles later: o_exp=15, both magnitudes 0x2000, signs 0, o_nan=o_inf=0.
- 0x3C00 + 0xB800 (1.0, -0.5) → o_exp=15, lhs mag 0x2000, rhs mag 0x1000, rhs sign 1.
- 0x3C00 + 0x0001 (d=14) → rhs mag 0x0001 with FP16_ALIGN_STICKY_EN, 0x0000 without; o_exp=15.
- 0x7E00 + 0x3C00 → o_nan=1. 0x7C00 + 0xFC00 → o_nan=1. 0x7C00 + 0x3C00 → o_inf=1, o_lhs_sign=0.
- Back-to-back stream of 4 pairs with i_ready low for 3 cycles after the first o_valid:
  - Outputs stay stable during the stall.
  - o_ready drops once both stages are full.
  - All 4 results emerge in order, none lost or duplicated.
- Assert i_rst_n=0 for one cycle with 2 ops in flight → o_valid=0 and all outputs 0 next cycle. No stale result appears after release; o_ready=1.
